// File: rtl/pcie_trans_ndest_if.sv
// Source-side handshake bundle: write port into the main FIFO, per-destination pop strobes,
// registered pop data, non-empty flags and threshold backpressure.
interface pcie_trans_ndest_if #(
  parameter int BITNUMBER = 6,
  parameter int NUM_DEST  = 4
);
  logic [BITNUMBER-1:0]          data_in;
  logic                          push;
  logic [NUM_DEST-1:0]           pop;
  logic [NUM_DEST*BITNUMBER-1:0] data_out;
  logic [NUM_DEST-1:0]           can_pop;
  logic                          Main_pause;

  modport master (output data_in, push, pop, input data_out, can_pop, Main_pause);
  modport slave  (input data_in, push, pop, output data_out, can_pop, Main_pause);
endinterface

// File: rtl/pcie_trans_ndest.sv
// Main FIFO routed by top DSEL_W bits into NUM_DEST FIFOs; push->can_pop 2 cycles, pop->data_out 1 cycle.
// Main_pause is threshold-based and advisory; a push into a full, non-draining main FIFO latches ERROR. Option: PCIE_TRANS_STATS_EN.
module pcie_trans_ndest #(
  parameter int BITNUMBER = 6,
  parameter int LENGTH    = 4,
  parameter int NUM_DEST  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [3:0] Umbral_MF_prob,
  input  logic [3:0] Umbral_D_prob,
  output logic [3:0] state,
  output logic [3:0] next_state,
  pcie_trans_ndest_if.slave bus
`ifdef PCIE_TRANS_STATS_EN
  ,
  output logic [NUM_DEST*8-1:0] pop_count
`endif
);
  localparam int DSEL_W = $clog2(NUM_DEST);
  localparam int CW     = $clog2(LENGTH + 1);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_IDLE   = 4'd2;
  localparam logic [3:0] S_ACTIVE = 4'd3;
  localparam logic [3:0] S_ERROR  = 4'd4;

  logic [3:0]           um_mf, um_d;
  logic [BITNUMBER-1:0] main_head;
  logic [CW-1:0]        main_cnt;
  logic                 main_full, main_empty;
  logic [DSEL_W-1:0]    head_dest;
  logic [BITNUMBER-1:0] d_head [NUM_DEST];
  logic [CW-1:0]        d_cnt  [NUM_DEST];
  logic [NUM_DEST-1:0]  d_full, d_empty, d_wr, d_rd;
  logic                 run, xfer, main_wr, push_err, any_busy, d_pause;

  function automatic logic at_or_above(input logic [CW-1:0] cnt, input logic [3:0] thr);
    return 5'(cnt) >= 5'(thr);
  endfunction

  // A pop frees its slot in the same cycle, so a full destination that is being popped still accepts the head.
  assign run       = (state != S_ERROR);
  assign head_dest = main_head[BITNUMBER-1 -: DSEL_W];
  assign d_rd      = bus.pop & ~d_empty & {NUM_DEST{run}};
  assign xfer      = run && !main_empty && (!d_full[head_dest] || d_rd[head_dest]);
  assign main_wr   = run && bus.push && (!main_full || xfer);
  assign push_err  = bus.push && main_full && !xfer && (state != S_RESET);
  assign any_busy  = !main_empty || !(&d_empty);

  always_comb begin
    d_wr            = '0;
    d_wr[head_dest] = xfer;
  end

  pcie_trans_fifo #(.W(BITNUMBER), .DEPTH(LENGTH)) u_main (
    .clk(clk), .reset(reset), .wr(main_wr), .rd(xfer), .wdata(bus.data_in),
    .rdata(main_head), .count(main_cnt), .full(main_full), .empty(main_empty)
  );

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
    pcie_trans_fifo #(.W(BITNUMBER), .DEPTH(LENGTH)) u_dest (
      .clk(clk), .reset(reset), .wr(d_wr[i]), .rd(d_rd[i]), .wdata(main_head),
      .rdata(d_head[i]), .count(d_cnt[i]), .full(d_full[i]), .empty(d_empty[i])
    );
  end

  always_comb begin
    d_pause = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      d_pause = d_pause | at_or_above(d_cnt[i], um_d);
    end
  end

  assign bus.Main_pause = at_or_above(main_cnt, um_mf) | d_pause | !run;
  assign bus.can_pop    = ~d_empty;

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:  next_state = S_INIT;
      S_INIT:   if (!init) next_state = S_IDLE;
      S_IDLE:   if (init) next_state = S_INIT;
                else if (any_busy) next_state = S_ACTIVE;
      S_ACTIVE: if (!any_busy) next_state = S_IDLE;
      default:  next_state = S_ERROR;
    endcase
    if (push_err) next_state = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RESET;
      um_mf        <= 4'(LENGTH - 1);
      um_d         <= 4'(LENGTH - 1);
      bus.data_out <= '0;
    end else begin
      state <= next_state;
      if (state == S_INIT) begin
        um_mf <= Umbral_MF_prob;
        um_d  <= Umbral_D_prob;
      end
      for (int i = 0; i < NUM_DEST; i++) begin
        if (d_rd[i]) bus.data_out[i*BITNUMBER +: BITNUMBER] <= d_head[i];
      end
    end
  end

`ifdef PCIE_TRANS_STATS_EN
  for (genvar i = 0; i < NUM_DEST; i++) begin : g_stats
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (d_rd[i] && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
    assign pop_count[i*8 +: 8] = cnt;
  end
`endif
endmodule

// Caller qualifies wr/rd; a write into a full FIFO is legal only together with a read.
module pcie_trans_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: tb/tb_pcie_trans_ndest.sv
// Randomised and directed traffic against a queue-level reference model with a decoupled pop scoreboard.
module tb_pcie_trans_ndest;
  localparam int BW  = 6;
  localparam int LEN = 4;
  localparam int ND  = 4;
  localparam int DW  = $clog2(ND);

  logic       clk = 1'b0;
  logic       rst, ini;
  logic [3:0] mf, dthr, state, next_state;
`ifdef PCIE_TRANS_STATS_EN
  logic [ND*8-1:0] pop_count;
`endif

  pcie_trans_ndest_if #(.BITNUMBER(BW), .NUM_DEST(ND)) bus ();

  pcie_trans_ndest #(.BITNUMBER(BW), .LENGTH(LEN), .NUM_DEST(ND)) dut (
    .clk(clk), .reset(rst), .init(ini), .Umbral_MF_prob(mf), .Umbral_D_prob(dthr),
    .state(state), .next_state(next_state), .bus(bus)
`ifdef PCIE_TRANS_STATS_EN
    , .pop_count(pop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues, words move between them by the routing rules.
  logic [BW-1:0] mq [$];
  logic [BW-1:0] dq [ND][$];
  logic [BW-1:0] eq [ND][$];
  logic [BW-1:0] m_dout [ND];
  int m_state, m_mf, m_d;
  int m_pc [ND];

  function automatic logic m_pause();
    logic p = (mq.size() >= m_mf) || (m_state == 4);
    for (int i = 0; i < ND; i++) if (dq[i].size() >= m_d) p = 1'b1;
    return p;
  endfunction

  function automatic logic [ND-1:0] m_canpop();
    logic [ND-1:0] v = '0;
    for (int i = 0; i < ND; i++) v[i] = (dq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [ND*BW-1:0] m_dout_vec();
    logic [ND*BW-1:0] v = '0;
    for (int i = 0; i < ND; i++) v[i*BW +: BW] = m_dout[i];
    return v;
  endfunction

  task automatic model_edge(input logic ps, input logic [BW-1:0] din, input logic [ND-1:0] pp);
    int msz, hd, ns;
    logic any_ne, xfer;
    logic [ND-1:0] popped;
    logic [BW-1:0] w;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < ND; i++) begin
        dq[i].delete(); eq[i].delete(); m_dout[i] = '0; m_pc[i] = 0;
      end
      m_state = 0; m_mf = LEN - 1; m_d = LEN - 1;
      return;
    end
    msz = mq.size();
    any_ne = (msz != 0);
    for (int i = 0; i < ND; i++) if (dq[i].size() != 0) any_ne = 1'b1;
    if (m_state == 1) begin m_mf = int'(mf); m_d = int'(dthr); end
    case (m_state)
      0: ns = 1;
      1: ns = ini ? 1 : 2;
      2: ns = ini ? 1 : (any_ne ? 3 : 2);
      3: ns = any_ne ? 3 : 2;
      default: ns = 4;
    endcase
    if (m_state != 4) begin
      popped = '0;
      for (int i = 0; i < ND; i++) popped[i] = pp[i] && (dq[i].size() != 0);
      xfer = 1'b0; hd = 0;
      if (msz != 0) begin
        hd = int'(mq[0]) >> (BW - DW);
        xfer = (dq[hd].size() < LEN) || popped[hd];
      end
      for (int i = 0; i < ND; i++) if (popped[i]) begin
        w = dq[i].pop_front();
        m_dout[i] = w;
        eq[i].push_back(w);
        if (m_pc[i] < 255) m_pc[i]++;
      end
      if (xfer) dq[hd].push_back(mq.pop_front());
      if (ps && (msz < LEN || xfer)) mq.push_back(din);
      if (ps && msz == LEN && !xfer && m_state != 0) ns = 4;
    end
    m_state = ns;
  endtask

  task automatic cyc(input logic ps, input logic [BW-1:0] din, input logic [ND-1:0] pp);
    bus.push = ps; bus.data_in = din; bus.pop = pp;
    @(posedge clk);
    model_edge(ps, din, pp);
    @(negedge clk);
    chk("can_pop",    32'(bus.can_pop),    32'(m_canpop()));
    chk("main_pause", 32'(bus.Main_pause), 32'(m_pause()));
    chk("state",      32'(state),          32'(m_state));
    chk("data_out",   32'(bus.data_out),   32'(m_dout_vec()));
  endtask

  task automatic do_reset(input logic [3:0] t_mf, input logic [3:0] t_d);
    rst = 1'b1; ini = 1'b1; mf = t_mf; dthr = t_d;
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    rst = 1'b0;
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    ini = 1'b0;
    cyc(1'b0, '0, '0);
  endtask

  // Scoreboard monitor: an accepted pop must show the oldest expected word for that destination.
  initial begin
    logic [ND-1:0] hs;
    logic [BW-1:0] w;
    forever begin
      @(negedge clk); #3;
      hs = (rst || state == 4'd4) ? '0 : (bus.pop & bus.can_pop);
      @(posedge clk); #1;
      for (int i = 0; i < ND; i++) if (hs[i]) begin
        if (eq[i].size() == 0) chk("sb_pending", 32'(eq[i].size() != 0), 32'd1);
        else begin
          w = eq[i].pop_front();
          chk("sb_data", 32'(bus.data_out[i*BW +: BW]), 32'(w));
        end
      end
    end
  end

  initial begin
    logic ps;
    bus.push = 1'b0; bus.data_in = '0; bus.pop = '0;

    // Reset, init sequence and reset-state outputs
    rst = 1'b1; ini = 1'b1; mf = 4'd3; dthr = 4'd2;
    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_next_state", 32'(next_state), 32'd1);
    chk("rst_can_pop", 32'(bus.can_pop), 32'd0);
    chk("rst_pause", 32'(bus.Main_pause), 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    rst = 1'b0;
    cyc(1'b0, '0, '0);
    chk("init_state", 32'(state), 32'd1);
    cyc(1'b0, '0, '0);
    ini = 1'b0;
    cyc(1'b0, '0, '0);
    chk("idle_state", 32'(state), 32'd2);

    // Single word to dest 2
    cyc(1'b1, 6'h25, '0);
    cyc(1'b0, '0, '0);
    chk("t2_can_pop", 32'(bus.can_pop), 32'b0100);
    chk("t2_active", 32'(state), 32'd3);
    cyc(1'b0, '0, 4'b0100);
    chk("t2_data_out", 32'(bus.data_out[17:12]), 32'h25);
    cyc(1'b0, '0, '0);
    chk("t2_back_idle", 32'(state), 32'd2);

    // Dest 0 backpressure at threshold 2, then drain
    cyc(1'b1, 6'h01, '0);
    cyc(1'b1, 6'h02, '0);
    cyc(1'b1, 6'h03, '0);
    chk("t3_pause", 32'(bus.Main_pause), 32'd1);
    cyc(1'b0, '0, '0);
    for (int k = 0; k < 4; k++) cyc(1'b0, '0, 4'b0001);

    // Overflow into ERROR, pops ignored, reset recovers
    for (int k = 0; k < 9; k++) cyc(1'b1, 6'(6'h30 + k), '0);
    chk("t4_error", 32'(state), 32'd4);
    chk("t4_pause", 32'(bus.Main_pause), 32'd1);
    cyc(1'b1, 6'h3F, 4'b1000);
    do_reset(4'd3, 4'd2);
    chk("t4_recover_state", 32'(state), 32'd2);
    chk("t4_recover_can_pop", 32'(bus.can_pop), 32'd0);

    // Pop on empty dest, then push+pop with everything full
    cyc(1'b0, '0, 4'b0010);
    chk("t5_no_error", 32'(state), 32'd2);
    for (int k = 0; k < 8; k++) cyc(1'b1, 6'(k), '0);
    cyc(1'b1, 6'h0A, 4'b0001);
    chk("t5_full_pushpop", 32'(state), 32'd3);
    for (int k = 0; k < 10; k++) cyc(1'b0, '0, 4'b0001);

    // Random episodes with random thresholds, occasional pause violations
    for (int ep = 0; ep < 12; ep++) begin
      do_reset(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      for (int k = 0; k < 50; k++) begin
        ps = ($urandom_range(0, 3) != 0) && (!m_pause() || $urandom_range(0, 15) == 0);
        cyc(ps, 6'($urandom), 4'($urandom));
      end
    end

`ifdef PCIE_TRANS_STATS_EN
    do_reset(4'd3, 4'd2);
    for (int k = 0; k < 300; k++) cyc(1'b1, 6'(k & 15), 4'b0001);
    for (int i = 0; i < ND; i++) chk("pop_count", 32'(pop_count[i*8 +: 8]), 32'(m_pc[i]));
    chk("pop_count_sat", 32'(pop_count[7:0]), 32'd255);
    rst = 1'b1;
    cyc(1'b0, '0, '0);
    chk("pop_count_clr", 32'(pop_count), 32'd0);
    chk("midrst_can_pop", 32'(bus.can_pop), 32'd0);
    rst = 1'b0;
`endif

    cyc(1'b0, '0, '0);
    cyc(1'b0, '0, '0);
    for (int i = 0; i < ND; i++) chk("sb_drain", 32'(eq[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
